// File: rtl/div_unit_if.sv
// Operand/result bundle between an issuer and the iterative divider.
// Optional div_zero flag exists only when DIV_ZERO_FAST_EN is defined.
interface div_unit_if #(parameter int WIDTH = 32);
   logic             ena;
   logic             start;
   logic             is_signed;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
`ifdef DIV_ZERO_FAST_EN
   logic             div_zero;
`endif

   modport slave (
      input  ena, start, is_signed, dividend, divisor,
      output busy, done, q, r
`ifdef DIV_ZERO_FAST_EN
      , output div_zero
`endif
   );

   modport master (
      output ena, start, is_signed, dividend, divisor,
      input  busy, done, q, r
`ifdef DIV_ZERO_FAST_EN
      , input  div_zero
`endif
   );
endinterface

// File: rtl/div_unit.sv
// Iterative restoring divider (DIV/DIVU), one quotient bit per cycle, results held until next start.
// Build option DIV_ZERO_FAST_EN: zero divisor skips iterations and raises div_zero with done.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic       clk,
   input  logic       rst,
   div_unit_if.slave  bus
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_CALC = 2'd1;
   localparam logic [1:0] S_FIN  = 2'd2;
   localparam int         CW     = $clog2(WIDTH + 1);
   localparam logic [CW-1:0] LAST = CW'(WIDTH);

   logic [1:0]       state;
   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] rem, quo, dvs, dvd_raw;
   logic             neg_q, neg_r, dz;
   logic             busy_q, done_q;
   logic [WIDTH-1:0] q_q, r_q;

   logic [WIDTH:0]   shifted;
   logic [WIDTH-1:0] diff, fin_q, fin_r, abs_dvd, abs_dvs;
   logic             dvd_neg, dvs_neg;

   always_comb begin
      dvd_neg = bus.is_signed & bus.dividend[WIDTH-1];
      dvs_neg = bus.is_signed & bus.divisor[WIDTH-1];
      abs_dvd = dvd_neg ? -bus.dividend : bus.dividend;
      abs_dvs = dvs_neg ? -bus.divisor  : bus.divisor;
      // Partial remainder is kept one bit wider during the compare; the difference always fits WIDTH.
      shifted = {rem, quo[WIDTH-1]};
      diff    = shifted[WIDTH-1:0] - dvs;
      fin_q   = dz ? '1      : (neg_q ? -quo : quo);
      fin_r   = dz ? dvd_raw : (neg_r ? -rem : rem);
   end

`ifdef DIV_ZERO_FAST_EN
   logic dz_flag;
   assign bus.div_zero = dz_flag;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= S_IDLE;
         cnt     <= '0;
         rem     <= '0;
         quo     <= '0;
         dvs     <= '0;
         dvd_raw <= '0;
         neg_q   <= 1'b0;
         neg_r   <= 1'b0;
         dz      <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         q_q     <= '0;
         r_q     <= '0;
`ifdef DIV_ZERO_FAST_EN
         dz_flag <= 1'b0;
`endif
      end else if (bus.ena) begin
         case (state)
            S_IDLE: begin
               if (bus.start) begin
                  rem     <= '0;
                  quo     <= abs_dvd;
                  dvs     <= abs_dvs;
                  dvd_raw <= bus.dividend;
                  neg_q   <= dvd_neg ^ dvs_neg;
                  neg_r   <= dvd_neg;
                  dz      <= (bus.divisor == '0);
                  busy_q  <= 1'b1;
                  state   <= S_CALC;
`ifdef DIV_ZERO_FAST_EN
                  // Zero divisor jumps straight to the finishing edge.
                  cnt     <= (bus.divisor == '0) ? LAST : '0;
`else
                  cnt     <= '0;
`endif
               end
            end
            S_CALC: begin
               if (cnt == LAST) begin
                  q_q    <= fin_q;
                  r_q    <= fin_r;
                  done_q <= 1'b1;
                  state  <= S_FIN;
`ifdef DIV_ZERO_FAST_EN
                  dz_flag <= dz;
`endif
               end else begin
                  if (shifted >= {1'b0, dvs}) begin
                     rem <= diff;
                     quo <= {quo[WIDTH-2:0], 1'b1};
                  end else begin
                     rem <= shifted[WIDTH-1:0];
                     quo <= {quo[WIDTH-2:0], 1'b0};
                  end
                  cnt <= cnt + 1'b1;
               end
            end
            S_FIN: begin
               done_q <= 1'b0;
               busy_q <= 1'b0;
               state  <= S_IDLE;
`ifdef DIV_ZERO_FAST_EN
               dz_flag <= 1'b0;
`endif
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.q    = q_q;
   assign bus.r    = r_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed + random checks of div_unit against an arithmetic reference model.
module tb_div_unit;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   div_unit_if #(.WIDTH(32)) bus ();
   div_unit #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic void ref_div(input logic s, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] eq, output logic [31:0] er);
      int sa, sb;
      sa = a;
      sb = b;
      if (b == 0) begin
         eq = 32'hFFFF_FFFF; er = a;
      end else if (!s) begin
         eq = a / b; er = a % b;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         eq = 32'h8000_0000; er = 0;
      end else begin
         eq = sa / sb; er = sa % sb;
      end
   endfunction

   function automatic int exp_lat(input logic [31:0] b);
`ifdef DIV_ZERO_FAST_EN
      return (b == 0) ? 1 : 33;
`else
      return 33 + ((b == 0) ? 0 : 0);
`endif
   endfunction

   task automatic run_op(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] eq, er;
      int n, nb;
      ref_div(s, a, b, eq, er);
      bus.start = 1'b1; bus.is_signed = s; bus.dividend = a; bus.divisor = b;
      @(negedge clk);
      bus.start = 1'b0; bus.is_signed = ~s;
      bus.dividend = $urandom; bus.divisor = $urandom;
      n = 0; nb = 0;
      forever begin
         if (bus.busy) nb++;
         if (bus.done || n >= 100) break;
         @(negedge clk);
         n++;
      end
      chk({tag, " latency"}, 32'(n), 32'(exp_lat(b)));
      chk({tag, " q"}, bus.q, eq);
      chk({tag, " r"}, bus.r, er);
`ifdef DIV_ZERO_FAST_EN
      chk({tag, " div_zero"}, {31'b0, bus.div_zero}, {31'b0, (b == 0)});
`endif
      @(negedge clk);
      chk({tag, " busy cycles"}, 32'(nb), 32'(exp_lat(b) + 1));
      chk({tag, " idle after"}, {30'b0, bus.busy, bus.done}, 32'd0);
      chk({tag, " q held"}, bus.q, eq);
   endtask

   initial begin
      logic [31:0] a, b, eq, er;
      logic        s;
      int          n;
      bus.ena = 1'b1; bus.start = 1'b0; bus.is_signed = 1'b0;
      bus.dividend = '0; bus.divisor = '0;
      #12;
      chk("reset busy/done", {30'b0, bus.busy, bus.done}, 32'd0);
      chk("reset q", bus.q, 32'd0);
      chk("reset r", bus.r, 32'd0);
      @(negedge clk); rst = 1'b0;
      @(negedge clk);

      run_op("divu 100/7",    1'b0, 32'd100, 32'd7);
      run_op("div -100/7",    1'b1, -32'sd100, 32'd7);
      run_op("div 100/-7",    1'b1, 32'd100, -32'sd7);
      run_op("div ovf",       1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("divu max/1",    1'b0, 32'hFFFF_FFFF, 32'd1);
      run_op("divu x/0",      1'b0, 32'h1234, 32'd0);
      run_op("div negx/0",    1'b1, 32'hFFFF_1234, 32'd0);
      run_op("divu big/big",  1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFE);

      for (int i = 0; i < 20; i++) begin
         s = 1'($urandom_range(0, 1));
         a = $urandom;
         case ($urandom_range(0, 3))
            0:       b = $urandom;
            1:       b = $urandom_range(1, 100);
            2:       b = -$urandom_range(1, 100);
            default: b = (i % 5 == 0) ? 32'd0 : {16'd0, 16'($urandom)};
         endcase
         run_op($sformatf("rand%0d", i), s, a, b);
      end

      // Second start mid-run ignored; ena low for 5 cycles stretches latency to 38.
      ref_div(1'b0, 32'd100, 32'd7, eq, er);
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd100; bus.divisor = 32'd7;
      @(negedge clk);
      bus.start = 1'b0;
      n = 0;
      forever begin
         if (bus.done || n >= 100) break;
         @(negedge clk);
         n++;
         if (bus.done) break;
         bus.start = (n == 3);
         if (n == 3) begin bus.dividend = 32'd999; bus.divisor = 32'd3; bus.is_signed = 1'b1; end
         bus.ena = !(n >= 10 && n <= 14);
      end
      bus.start = 1'b0; bus.ena = 1'b1;
      chk("stall latency", 32'(n), 32'd38);
      chk("stall q", bus.q, eq);
      chk("stall r", bus.r, er);
      @(negedge clk);
      chk("stall idle", {30'b0, bus.busy, bus.done}, 32'd0);

      // Asynchronous reset at iteration 10.
      bus.start = 1'b1; bus.is_signed = 1'b0; bus.dividend = 32'd1000; bus.divisor = 32'd3;
      @(negedge clk);
      bus.start = 1'b0;
      repeat (10) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      chk("async rst busy", {31'b0, bus.busy}, 32'd0);
      chk("async rst q", bus.q, 32'd0);
      chk("async rst r", bus.r, 32'd0);
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      run_op("after rst", 1'b1, -32'sd1000, 32'd3);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
